// File: rtl/tt_lq_drain_sequencer.sv
// Vector load-buffer drain sequencer: accepts one drain request, then issues
// in-order load-buffer reads with lqid wrap-around, committing one entry per beat.
module tt_lq_drain_sequencer #(
    parameter int LQ_DEPTH = 8,
    parameter int LQID_W   = 3,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_drain_req,
    input  logic [CNT_W-1:0]  i_drain_ref_count,
    input  logic [LQID_W-1:0] i_drain_lqid_start,
    output logic              o_draining,
    output logic              o_lq_rd_valid,
    output logic [LQID_W-1:0] o_lq_rd_lqid,
    input  logic              i_lq_rd_ready,
    output logic              o_lq_commit,
    output logic [LQID_W-1:0] o_lq_commit_lqid,
    input  logic              i_abort,
    output logic              o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LQID_W-1:0] LQID_LAST = LQID_W'(LQ_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t            state;
    logic [LQID_W-1:0] ptr;
    logic [CNT_W-1:0]  remaining;
    logic              fire;
    logic [LQID_W-1:0] ptr_inc;

    assign fire    = o_lq_rd_valid & i_lq_rd_ready;
    assign ptr_inc = (ptr == LQID_LAST) ? '0 : ptr + LQID_W'(1);

    assign o_lq_rd_lqid     = ptr;
    assign o_lq_commit      = fire;
    assign o_lq_commit_lqid = ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            remaining     <= '0;
            o_draining    <= 1'b0;
            o_lq_rd_valid <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // abort wins over a request arriving in the same cycle
                    if (i_drain_req && !i_abort) begin
                        ptr        <= i_drain_lqid_start;
                        remaining  <= i_drain_ref_count;
                        o_draining <= 1'b1;
                        if (i_drain_ref_count != '0) begin
                            state         <= ISSUE;
                            o_lq_rd_valid <= 1'b1;
                        end else begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (fire) begin
                        ptr       <= ptr_inc;
                        remaining <= remaining - CNT_ONE;
                    end
                    if (i_abort) begin
                        state         <= IDLE;
                        o_draining    <= 1'b0;
                        o_lq_rd_valid <= 1'b0;
                    end else if (fire && remaining == CNT_ONE) begin
                        state         <= DONE;
                        o_lq_rd_valid <= 1'b0;
                        o_done        <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    o_draining <= 1'b0;
                    o_done     <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    o_draining    <= 1'b0;
                    o_lq_rd_valid <= 1'b0;
                    o_done        <= 1'b0;
                end
            endcase
        end
    end

endmodule
